// File: rtl/cmm_req_arbiter.sv
// rtl/cmm_req_arbiter.sv - round-robin request arbiter in front of one complex_matrix_mul engine
// Latches the winner's operands, runs the engine under a watchdog and returns the tagged result.
module cmm_req_arbiter #(
  parameter int N       = 16,
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32*N-1:0] req_h_flat,
  input  logic [NREQ*16*N-1:0] req_s_flat,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [16*N-1:0]      resp_sq_flat,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 eng_start,
  output logic [32*N-1:0]      eng_h_flat,
  output logic [16*N-1:0]      eng_s_flat,
  input  logic                 eng_done,
  input  logic [16*N-1:0]      eng_sq_flat
);

  localparam int HW = 32 * N;
  localparam int SW = 16 * N;
  localparam int IW = IDW + 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, grant_id, pick_id, rr_nxt;
  logic [IW-1:0]  rr_wrap;
  logic           pick_found, handshake;
  logic [CW-1:0]  count;
  logic [HW-1:0]  hold_h;
  logic [SW-1:0]  hold_s;
  logic [SW-1:0]  sq_r;
  logic           err_r;

  // First valid requester scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin : pick
    logic [IW-1:0] idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + IW'(k);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!pick_found && req_valid[idx[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    rr_wrap = {1'b0, grant_id} + IW'(1);
    if (rr_wrap >= IW'(NREQ)) rr_wrap = '0;
    rr_nxt = rr_wrap[IDW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // req_ready is gated by rst_n so it is low during reset even with requests pending.
  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    handshake  = 1'b0;
    eng_start  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (rst_n && pick_found) begin
          req_ready[pick_id] = 1'b1;
          handshake          = 1'b1;
          state_nx           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        state_nx  = S_BUSY;
      end
      S_BUSY: begin
        if (eng_done || count == CW'(TIMEOUT - 1)) state_nx = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      count    <= '0;
      hold_h   <= '0;
      hold_s   <= '0;
      sq_r     <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (handshake) begin
            hold_h   <= req_h_flat[int'(pick_id) * HW +: HW];
            hold_s   <= req_s_flat[int'(pick_id) * SW +: SW];
            grant_id <= pick_id;
          end
        end
        S_ISSUE: count <= '0;
        S_BUSY: begin
          // A done pulse on the last watchdog cycle still counts as success.
          if (eng_done) begin
            sq_r  <= eng_sq_flat;
            err_r <= 1'b0;
          end else if (count == CW'(TIMEOUT - 1)) begin
            sq_r  <= '0;
            err_r <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) rr_ptr <= rr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign eng_h_flat   = hold_h;
  assign eng_s_flat   = hold_s;
  assign resp_id      = grant_id;
  assign resp_sq_flat = sq_r;
  assign resp_err     = err_r;

endmodule

// File: tb/tb_cmm_req_arbiter.sv
// tb/tb_cmm_req_arbiter.sv - directed bench for cmm_req_arbiter with a behavioural engine model
module tb_cmm_req_arbiter;
  localparam int N = 16, NREQ = 2, IDW = 1, TIMEOUT = 32;
  localparam int HW = 32 * N, SW = 16 * N;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*HW-1:0]   req_h_flat = '0;
  logic [NREQ*SW-1:0]   req_s_flat = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic [IDW-1:0]       resp_id;
  logic [SW-1:0]        resp_sq_flat;
  logic                 resp_err;
  logic                 busy;
  logic                 eng_start;
  logic [HW-1:0]        eng_h_flat;
  logic [SW-1:0]        eng_s_flat;
  logic                 eng_done;
  logic [SW-1:0]        eng_sq_flat;

  logic                 model_on = 1'b1;
  logic                 model_done = 1'b0;
  logic                 tb_done = 1'b0;
  logic [SW-1:0]        model_sq = '0;
  logic [SW-1:0]        model_res;

  int total = 0;
  int bad = 0;
  int both_ready = 0;

  assign eng_done    = model_done | tb_done;
  assign eng_sq_flat = model_sq;

  cmm_req_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_h_flat(req_h_flat), .req_s_flat(req_s_flat),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sq_flat(resp_sq_flat), .resp_err(resp_err),
    .busy(busy), .eng_start(eng_start),
    .eng_h_flat(eng_h_flat), .eng_s_flat(eng_s_flat),
    .eng_done(eng_done), .eng_sq_flat(eng_sq_flat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (req_ready == 2'b11) both_ready++;

  // Complex element e occupies [e*2N +: 2N]: real in the low half, imaginary in the high half.
  function automatic logic [HW-1:0] h_diag(input int d);
    logic [HW-1:0] h = '0;
    for (int i = 0; i < 4; i++) h[(i * 5) * 2 * N +: N] = N'(d);
    return h;
  endfunction

  function automatic logic [SW-1:0] s_pat(input int base, input int mult);
    logic [SW-1:0] s = '0;
    for (int e = 0; e < 8; e++) begin
      s[e * 2 * N +: N]     = N'(mult * (base + e));
      s[e * 2 * N + N +: N] = N'(-mult * (base + e));
    end
    return s;
  endfunction

  function automatic logic [SW-1:0] cm_mul(input logic [HW-1:0] h, input logic [SW-1:0] s);
    logic [SW-1:0] q = '0;
    longint re, im, hr, hi, sr, si;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) begin
        re = 0; im = 0;
        for (int k = 0; k < 4; k++) begin
          hr = longint'($signed(h[(i * 4 + k) * 2 * N +: N]));
          hi = longint'($signed(h[(i * 4 + k) * 2 * N + N +: N]));
          sr = longint'($signed(s[(k * 2 + j) * 2 * N +: N]));
          si = longint'($signed(s[(k * 2 + j) * 2 * N + N +: N]));
          re += hr * sr - hi * si;
          im += hr * si + hi * sr;
        end
        q[(i * 2 + j) * 2 * N +: N]     = N'(re >>> 8);
        q[(i * 2 + j) * 2 * N + N +: N] = N'(im >>> 8);
      end
    return q;
  endfunction

  // Engine model: done pulse lands so that resp_valid rises 10 edges after the request handshake.
  always begin
    @(posedge clk);
    if (eng_start && model_on) begin
      model_res = cm_mul(eng_h_flat, eng_s_flat);
      repeat (8) @(posedge clk);
      #1;
      model_sq   = model_res;
      model_done = 1'b1;
      @(posedge clk);
      #1 model_done = 1'b0;
    end
  end

  task automatic wait_resp(output int lat, output int starts);
    bit got = 0;
    lat = 0;
    starts = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (eng_start) starts++;
      if (resp_valid) got = 1;
      else lat++;
    end
    if (!got) lat = -1;
  endtask

  task automatic ack_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    @(negedge clk);
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL rst_eng_start got=%b exp=0", eng_start); end
    total++; if (resp_sq_flat !== '0 || resp_err !== 1'b0 || resp_id !== '0) begin
      bad++; $display("FAIL rst_resp_regs got id=%0d err=%b sq=%h exp all 0", resp_id, resp_err, resp_sq_flat);
    end
    total++; if (eng_h_flat !== '0 || eng_s_flat !== '0) begin bad++; $display("FAIL rst_eng_operands not zero"); end
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_first_grant got=%b exp=01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_ready;
    logic [SW-1:0]   exp_sq;
    int lat, starts;
    @(negedge clk);
    req_h_flat = {h_diag(512), h_diag(256)};
    req_s_flat = {s_pat(10, 1), s_pat(0, 1)};
    req_valid  = 2'b11;
    for (int t = 0; t < 4; t++) begin
      #1;
      exp_ready = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_sq    = (t % 2 == 0) ? s_pat(0, 1) : s_pat(10, 2);
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rr_ready%0d got=%b exp=%b", t, req_ready, exp_ready); end
      @(posedge clk);
      wait_resp(lat, starts);
      total++; if (resp_id !== IDW'(t % 2)) begin bad++; $display("FAIL rr_id%0d got=%0d exp=%0d", t, resp_id, t % 2); end
      total++; if (resp_sq_flat !== exp_sq) begin bad++; $display("FAIL rr_sq%0d got=%h exp=%h", t, resp_sq_flat, exp_sq); end
      ack_resp();
      @(negedge clk);
    end
    req_valid = 2'b00;
    total++; if (both_ready !== 0) begin bad++; $display("FAIL rr_both_ready cycles got=%0d exp=0", both_ready); end
  endtask

  task automatic test_single();
    int lat, starts;
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_resp(lat, starts);
    total++; if (lat !== 10) begin bad++; $display("FAIL single_latency got=%0d exp=10", lat); end
    total++; if (starts !== 1) begin bad++; $display("FAIL single_starts got=%0d exp=1", starts); end
    total++; if (resp_sq_flat !== s_pat(0, 1)) begin bad++; $display("FAIL single_sq got=%h exp=%h", resp_sq_flat, s_pat(0, 1)); end
    total++; if (resp_id !== 1'b0 || resp_err !== 1'b0) begin bad++; $display("FAIL single_id_err got id=%0d err=%b exp 0/0", resp_id, resp_err); end
    ack_resp();
    @(negedge clk);
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_after got valid=%b busy=%b exp 0/0", resp_valid, busy); end
  endtask

  task automatic test_resp_hold();
    int lat, starts;
    @(negedge clk);
    req_valid = 2'b01;
    @(posedge clk);
    wait_resp(lat, starts);
    for (int c = 0; c < 10; c++) begin
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid%0d got=%b exp=1", c, resp_valid); end
      total++; if (resp_sq_flat !== s_pat(0, 1) || resp_id !== 1'b0) begin bad++; $display("FAIL hold_data%0d got=%h exp=%h", c, resp_sq_flat, s_pat(0, 1)); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL hold_req_ready%0d got=%b exp=00", c, req_ready); end
      total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL hold_eng_start%0d got=%b exp=0", c, eng_start); end
      @(negedge clk);
    end
    req_valid = 2'b00;
    ack_resp();
  endtask

  task automatic test_timeout();
    int lat, starts;
    model_on = 1'b0;
    @(negedge clk);
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_resp(lat, starts);
    total++; if (lat !== TIMEOUT + 1) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", lat, TIMEOUT + 1); end
    total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", resp_err); end
    total++; if (resp_sq_flat !== '0) begin bad++; $display("FAIL to_sq got=%h exp=0", resp_sq_flat); end
    ack_resp();
    model_on = 1'b1;
    @(negedge clk);
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_resp(lat, starts);
    total++; if (lat !== 10 || resp_err !== 1'b0) begin bad++; $display("FAIL to_recover got lat=%0d err=%b exp 10/0", lat, resp_err); end
    total++; if (resp_sq_flat !== s_pat(0, 1)) begin bad++; $display("FAIL to_recover_sq got=%h exp=%h", resp_sq_flat, s_pat(0, 1)); end
    ack_resp();
  endtask

  task automatic test_reset_busy();
    int lat, starts;
    model_on = 1'b0;
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rb_grant got=%b exp=10", req_ready); end
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rb_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b00 || busy !== 1'b0 || eng_start !== 1'b0 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL rb_ctrl got ready=%b busy=%b start=%b valid=%b exp all 0", req_ready, busy, eng_start, resp_valid);
    end
    total++; if (resp_sq_flat !== '0 || resp_err !== 1'b0 || resp_id !== '0 || eng_h_flat !== '0 || eng_s_flat !== '0) begin
      bad++; $display("FAIL rb_data got id=%0d err=%b sq=%h exp all 0", resp_id, resp_err, resp_sq_flat);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_sq_flat !== '0) begin
      bad++; $display("FAIL rb_late_done got valid=%b busy=%b sq=%h exp 0", resp_valid, busy, resp_sq_flat);
    end
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rb_next_grant got=%b exp=01", req_ready); end
    model_on = 1'b1;
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_resp(lat, starts);
    total++; if (resp_id !== 1'b0 || resp_err !== 1'b0 || resp_sq_flat !== s_pat(0, 1)) begin
      bad++; $display("FAIL rb_next_resp got id=%0d err=%b sq=%h exp 0/0/%h", resp_id, resp_err, resp_sq_flat, s_pat(0, 1));
    end
    ack_resp();
  endtask

  task automatic test_operand_hold();
    bit got = 0;
    @(negedge clk);
    req_h_flat = {h_diag(512), h_diag(256)};
    req_s_flat = {s_pat(10, 1), s_pat(20, 1)};
    req_valid  = 2'b01;
    @(posedge clk);
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      req_valid = 2'b00;
      for (int w = 0; w < NREQ * HW / 32; w++) req_h_flat[w * 32 +: 32] = $urandom;
      for (int w = 0; w < NREQ * SW / 32; w++) req_s_flat[w * 32 +: 32] = $urandom;
      if (resp_valid) got = 1;
      else if (c < 10) begin
        total++; if (eng_h_flat !== h_diag(256)) begin bad++; $display("FAIL oh_eng_h%0d got=%h exp=%h", c, eng_h_flat, h_diag(256)); end
        total++; if (eng_s_flat !== s_pat(20, 1)) begin bad++; $display("FAIL oh_eng_s%0d got=%h exp=%h", c, eng_s_flat, s_pat(20, 1)); end
      end
    end
    total++; if (!got) begin bad++; $display("FAIL oh_resp got=no response exp=response"); end
    total++; if (resp_sq_flat !== s_pat(20, 1) || resp_err !== 1'b0) begin
      bad++; $display("FAIL oh_sq got=%h err=%b exp=%h err=0", resp_sq_flat, resp_err, s_pat(20, 1));
    end
    ack_resp();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_resp_hold();
    test_timeout();
    test_reset_busy();
    test_operand_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
